// File: rtl/im_arbiter.sv
// rtl/im_arbiter.sv - two-requester instruction memory arbiter with 1-cycle read responses
// Optional feature macro: IM_ARB_ROUND_ROBIN_EN (round-robin on conflict; default is fetch priority)
module im_arbiter #(
  parameter int MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  output logic        f_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] im_addr,
  input  logic [31:0] im_instr
);

  // Highest byte address at which a whole word still fits in the memory.
  localparam logic [31:0] LP_LAST_WORD = 32'(MEM_BYTES - 4);

  logic        w_f_legal;
  logic        w_d_legal;
  logic        w_f_wins;
  logic        w_f_gnt;
  logic        w_d_gnt;

  // 1 = debug side won the most recent grant.
  logic        r_last_d;

  logic        r_f_rvalid;
  logic        r_f_err;
  logic [31:0] r_f_rdata;
  logic        r_d_rvalid;
  logic        r_d_err;
  logic [31:0] r_d_rdata;

  // Address legality: word aligned and fully inside the memory.
  always_comb begin
    w_f_legal = (f_addr[1:0] == 2'b00) && (f_addr <= LP_LAST_WORD);
    w_d_legal = (d_addr[1:0] == 2'b00) && (d_addr <= LP_LAST_WORD);
  end

`ifdef IM_ARB_ROUND_ROBIN_EN
  // On conflict, fetch wins only if debug won last time.
  assign w_f_wins = r_last_d;
`else
  // Fixed priority: fetch always wins; last-winner is tracked but not consulted.
  logic w_unused_last;
  assign w_f_wins      = 1'b1;
  assign w_unused_last = r_last_d;
`endif

  // Grants are combinational and held off entirely during reset.
  always_comb begin
    w_f_gnt = rst & f_req & (~d_req | w_f_wins);
    w_d_gnt = rst & d_req & (~f_req | ~w_f_wins);
  end

  // Memory address follows the granted side; illegal or idle addresses read as zero.
  always_comb begin
    im_addr = 32'h0;
    if (w_f_gnt && w_f_legal) begin
      im_addr = f_addr;
    end else if (w_d_gnt && w_d_legal) begin
      im_addr = d_addr;
    end
  end

  // Last-winner register; reset favours fetch on the first conflict.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_d <= 1'b1;
    end else if (w_f_gnt) begin
      r_last_d <= 1'b0;
    end else if (w_d_gnt) begin
      r_last_d <= 1'b1;
    end
  end

  // Fetch response: one-cycle pulse per grant, rdata held between responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_f_rvalid <= 1'b0;
      r_f_err    <= 1'b0;
      r_f_rdata  <= 32'h0;
    end else if (w_f_gnt) begin
      r_f_rvalid <= 1'b1;
      r_f_err    <= ~w_f_legal;
      r_f_rdata  <= w_f_legal ? im_instr : 32'h0;
    end else begin
      r_f_rvalid <= 1'b0;
      r_f_err    <= 1'b0;
    end
  end

  // Debug response: same behaviour as the fetch side.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_d_rvalid <= 1'b0;
      r_d_err    <= 1'b0;
      r_d_rdata  <= 32'h0;
    end else if (w_d_gnt) begin
      r_d_rvalid <= 1'b1;
      r_d_err    <= ~w_d_legal;
      r_d_rdata  <= w_d_legal ? im_instr : 32'h0;
    end else begin
      r_d_rvalid <= 1'b0;
      r_d_err    <= 1'b0;
    end
  end

  assign f_gnt    = w_f_gnt;
  assign d_gnt    = w_d_gnt;
  assign f_rvalid = r_f_rvalid;
  assign f_err    = r_f_err;
  assign f_rdata  = r_f_rdata;
  assign d_rvalid = r_d_rvalid;
  assign d_err    = r_d_err;
  assign d_rdata  = r_d_rdata;

endmodule
